// File: rtl/tt_um_dco.sv
// -----------------------------------------------------------------------------
// tt_um_dco -- digitally controlled oscillator for a Tiny Tapeout user tile.
//
// An 8-bit frequency code sets the increment of an ACC_W-bit phase accumulator.
// The accumulator MSB is the main square wave; its carry gives a one-clock tick
// per period; a divide-by-two flop gives an exact 50 % square wave at half rate;
// the next five accumulator bits are a coarse phase ramp.
//     f_out = f_clk * code / 2^ACC_W
//
// Parameters:
//   ACC_W    phase accumulator width, legal range 9..24 (default 10)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset, released on the next clk edge
//   ena      tile enable; 0 freezes every register (tick is forced low)
//   ui_in    frequency code (unsigned)
//   uio_in   unused
//   uo_out   [0] square wave, [1] wrap tick, [2] half-rate square wave,
//            [7:3] coarse phase acc[ACC_W-2:ACC_W-6]
//   uio_out  constant 0
//   uio_oe   constant 0 (bidirectionals are inputs)
//
// Build option:
//   CODE_LATCH_ON_WRAP_EN  when defined, a new code is captured only on an
//                          accumulator wrap (or while the held code is 0), so
//                          the running period always completes at the old rate.
// -----------------------------------------------------------------------------
module tt_um_dco #(
   parameter int ACC_W = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0]       code_r;
   logic [ACC_W-1:0] acc_r;
   logic             tick_r;
   logic             div2_r;

   logic [ACC_W:0]   sum_s;
   logic             carry_s;
   logic             code_load_s;
   logic             unused_s;

   // Next accumulator value, its carry, and whether the code register reloads.
   always_comb begin
      sum_s       = {1'b0, acc_r} + {{(ACC_W-7){1'b0}}, code_r};
      carry_s     = sum_s[ACC_W];
`ifdef CODE_LATCH_ON_WRAP_EN
      // Reloading while the code is 0 lets a stopped DCO be started at all.
      if (carry_s || (code_r == 8'd0)) begin
         code_load_s = 1'b1;
      end else begin
         code_load_s = 1'b0;
      end
`else
      code_load_s = 1'b1;
`endif
   end

   // Oscillator state: code capture, phase accumulation, wrap tick, divider.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_r <= 8'd0;
         acc_r  <= {ACC_W{1'b0}};
         tick_r <= 1'b0;
         div2_r <= 1'b0;
      end else if (ena) begin
         if (code_load_s) begin
            code_r <= ui_in;
         end else begin
            code_r <= code_r;
         end
         acc_r  <= sum_s[ACC_W-1:0];
         tick_r <= carry_s;
         if (carry_s) begin
            div2_r <= ~div2_r;
         end else begin
            div2_r <= div2_r;
         end
      end else begin
         // Disabled: phase and divider hold; the tick must not stretch.
         code_r <= code_r;
         acc_r  <= acc_r;
         tick_r <= 1'b0;
         div2_r <= div2_r;
      end
   end

   // Outputs are direct register taps, no combinational path from inputs.
   assign uo_out  = {acc_r[ACC_W-2 -: 5], div2_r, tick_r, acc_r[ACC_W-1]};
   assign uio_out = 8'd0;
   assign uio_oe  = 8'd0;

   assign unused_s = &{1'b0, uio_in, 1'b0};

endmodule

// File: tb/tb_tt_um_dco.sv
// -----------------------------------------------------------------------------
// tb_tt_um_dco -- directed self-checking bench for tt_um_dco (ACC_W = 10).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_tt_um_dco;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_checks = 0;
   int n_errors = 0;

   tt_um_dco dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   // Free-running 100 MHz-style clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock: through the rising edge, back to the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Hold reset two clocks with a code applied, release on a falling edge.
   task automatic restart(input logic [7:0] code);
      rst_n = 1'b0;
      ui_in = code;
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Length of the next complete high run and the low run after it on uo_out[idx].
   task automatic measure(input int idx, output int hi, output int lo);
      int n;
      n  = 0;
      hi = 0;
      lo = 0;
      while (uo_out[idx] === 1'b1 && n < 6000) begin step(); n++; end
      while (uo_out[idx] !== 1'b1 && n < 6000) begin step(); n++; end
      while (uo_out[idx] === 1'b1 && n < 6000) begin hi++; step(); n++; end
      while (uo_out[idx] !== 1'b1 && n < 6000) begin lo++; step(); n++; end
      if (n >= 6000) begin
         hi = -1;
         lo = -1;
      end
   endtask

   initial begin
      int bad;
      int n;
      int hi;
      int lo;
      int acc;
      logic [7:0] snap;

      ena    = 1'b1;
      uio_in = 8'hA5;
      ui_in  = 8'h00;
      rst_n  = 1'b0;

      // Reset hold with toggling code: everything stays zero.
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         ui_in = (i % 2 == 1) ? 8'h80 : 8'h00;
         step();
         if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) bad++;
      end
      check("reset_hold", bad, 0);

      // Code 0: outputs static at zero.
      ui_in = 8'h00;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 2000; i++) begin
         step();
         if (uo_out !== 8'h00) bad++;
      end
      check("code0_static", bad, 0);

      // Code 1: first tick 1025 clocks after release, then the periods.
      restart(8'h01);
      n = 0;
      do begin step(); n++; end while (uo_out[1] !== 1'b1 && n < 3000);
      check("code1_first_tick", n, 1025);
      measure(0, hi, lo);
      check("code1_sq_hi", hi, 512);
      check("code1_sq_lo", lo, 512);
      measure(1, hi, lo);
      check("code1_tick_hi", hi, 1);
      check("code1_tick_lo", lo, 1023);
      measure(2, hi, lo);
      check("code1_div2_hi", hi, 1024);
      check("code1_div2_lo", lo, 1024);

      // Power-of-two sweep: square wave halves 512>>k each, 50 % duty.
      for (int k = 0; k < 8; k++) begin
         ui_in = 8'(1 << k);
         step();
         step();
         measure(0, hi, lo);
         measure(0, hi, lo);
         check($sformatf("sweep%0d_hi", k), hi, 512 >> k);
         check($sformatf("sweep%0d_lo", k), lo, 512 >> k);
      end

      // Phase ramp at code 0x80 from a fresh start: acc = (k-1)*128 after edge k.
      restart(8'h80);
      for (int k = 1; k <= 17; k++) begin
         step();
         acc = ((k - 1) * 128) % 1024;
         check($sformatf("ramp%0d_phase", k), uo_out[7:3], (acc % 512) >> 4);
         check($sformatf("ramp%0d_sq", k), uo_out[0], (acc >= 512) ? 1 : 0);
         check($sformatf("ramp%0d_tick", k), uo_out[1], (k == 9 || k == 17) ? 1 : 0);
      end

      // Enable freeze mid-period at code 0x10 (64-clock period).
      restart(8'h10);
      n = 0;
      do begin step(); n++; end while (uo_out[1] !== 1'b1 && n < 200);
      check("code16_first_tick", n, 65);
      for (int i = 0; i < 10; i++) step();
      snap = uo_out;
      check("ena_snapshot", snap, 8'h54);
      ena = 1'b0;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (uo_out !== snap) bad++;
      end
      check("ena_frozen", bad, 0);
      ena = 1'b1;
      n = 110;
      do begin step(); n++; end while (uo_out[1] !== 1'b1 && n < 400);
      check("ena_period", n, 164);

      // Asynchronous reset between clock edges.
      for (int i = 0; i < 5; i++) step();
      check("pre_async", uo_out, 8'h28);
      #1 rst_n = 1'b0;
      #1 check("async_clear", uo_out, 8'h00);
      step();

      // Code switch 0x01 -> 0x80 with acc = 300.
      restart(8'h01);
      for (int i = 0; i < 301; i++) step();
      check("acc300_phase", uo_out[7:3], 18);
      ui_in = 8'h80;
      n = 0;
      do begin step(); n++; end while (uo_out[1] !== 1'b1 && n < 2000);
`ifdef CODE_LATCH_ON_WRAP_EN
      check("switch_tick", n, 724);
`else
      check("switch_tick", n, 7);
`endif
      measure(1, hi, lo);
      check("switch_tick_hi", hi, 1);
      check("switch_tick_lo", lo, 7);

      check("uio_out_zero", uio_out, 8'h00);
      check("uio_oe_zero", uio_oe, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
